slink_fifo_rd_stream: RTL and testbench
=======================================

# slink_fifo_rd_stream

Read-side adapter that sits directly downstream of the S-Link async FIFO, in the read clock domain. It turns the FIFO's first-word-fall-through read port (`rempty`/`rdata`/`rinc`) into a registered valid/ready stream. A 2-entry output buffer makes `fifo_rinc` independent of `m_ready`, so there is no combinational path from the consumer back to the FIFO pointers. It also provides a flush sequence that discards buffered and queued words, and optional statistics counters.

## Interface
Parameters:
- `DATA_SIZE`, default 40: word width. Must match the FIFO's `DATA_SIZE`.
- `STAT_WIDTH`, default 16: width of each statistics counter. Used only when statistics are compiled in.

Ports:
- `clk`  in  1  read-domain clock. Same clock as the FIFO's `rclk`.
- `reset_n`  in  1  reset, synchronous, active-low.
- `fifo_rempty`  in  1  FIFO empty flag. The head word is valid when this is 0.
- `fifo_rdata`  in  DATA_SIZE  FIFO head word (fall-through).
- `fifo_rinc`  out  1  pop request to the FIFO. The pop takes effect at the next `clk` edge.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accept.
- `m_data`  out  DATA_SIZE  output word.
- `flush`  in  1  level request: discard all buffered and queued words.
- `flush_busy`  out  1  high while in state FLUSH.
- `flush_done`  out  1  single-cycle pulse on leaving FLUSH.
- `stat_clr`  in  1  synchronous clear of both statistics counters. Present only with `SLINK_FIFO_RD_STATS_EN`.
- `stat_words`  out  STAT_WIDTH  count of words transferred (`m_valid & m_ready`). Present only with `SLINK_FIFO_RD_STATS_EN`.
- `stat_stalls`  out  STAT_WIDTH  count of `m_valid & ~m_ready` cycles. Present only with `SLINK_FIFO_RD_STATS_EN`.

## Operation
State machine: RUN (reset state) and FLUSH.

Buffer:
- 2 entries, FIFO order, occupancy `cnt` ranges 0..2.
- The head entry drives `m_data`.
- `m_valid = (cnt != 0) & (state == RUN)`.

Pop rule, combinational from registered state only:
- RUN: `fifo_rinc = ~fifo_rempty & (cnt < 2)`.
- FLUSH: `fifo_rinc = ~fifo_rempty`.

Buffer update in RUN:
- A pop writes `fifo_rdata` into the next free slot.
- `m_valid & m_ready` retires the head and shifts the second entry forward.
- `cnt_next = cnt + fifo_rinc − (m_valid & m_ready)`.
- Push and retire in the same cycle at `cnt == 1`: new word goes to the head, `cnt` stays 1.
- Push at `cnt == 2` is impossible by the pop rule. Retire at `cnt == 0` is impossible because `m_valid` is 0.

State transitions:
- RUN → FLUSH when `flush == 1`. On entry, `cnt` is cleared to 0 and the buffer contents are discarded, including any word popped in that same cycle.
- In FLUSH, popped words are discarded and `m_valid` is 0.
- FLUSH → RUN when `flush == 0 & fifo_rempty == 1`. `flush_done` is 1 for exactly the transition cycle.
- If `flush` stays high with an empty FIFO, the block remains in FLUSH.

Other rules:
- `m_data` holds its value when `m_valid` is 0. It is not cleared on retire.
- Reset (`reset_n == 0` at a `clk` edge): state RUN, `cnt` 0, `m_data` 0, `m_valid` 0, `flush_busy` 0, `flush_done` 0, stat counters 0.
- While `reset_n` is low, `fifo_rinc` is forced to 0 combinationally.
- Reset mid-stream drops buffered words. Words still in the FIFO are not popped, and resetting the FIFO is the owner's responsibility.

## Timing
- Latency: head word visible with `fifo_rempty == 0` at edge N appears on `m_data` with `m_valid == 1` after edge N+1 (one cycle).
- Throughput: one word per cycle while the FIFO is non-empty and `m_ready == 1`. Steady-state `cnt` is 1.
- Backpressure: when `m_ready` drops, at most 2 words are held. `fifo_rinc` deasserts the cycle `cnt` reaches 2.
- `m_valid`/`m_data` obey AXI-style rules: once valid, the word is stable until accepted, except when FLUSH is entered.
- `flush_busy` is registered: 1 from the cycle after `flush` is sampled high until `flush_done`.
- `fifo_rempty` updates with two-flop synchroniser latency after writes. A flush does not guarantee an empty FIFO if writes continue.

## Configuration
`SLINK_FIFO_RD_STATS_EN`

With the macro defined:
- `stat_clr`, `stat_words` and `stat_stalls` exist.
- Counters increment by 1 per qualifying cycle and saturate at all-ones.
- `stat_clr` has priority over increment.
- Counters keep counting in FLUSH (where `m_valid` is 0, so neither counter increments).

Without the macro:
- The ports and counters are absent.
- The remaining behaviour is identical.

## Structure
- Shared package `slink_fifo_pkg`:
  - state enum constants `ST_RUN = 1'b0`, `ST_FLUSH = 1'b1`
  - buffer depth constant `RD_BUF_DEPTH = 2`
- One sub-module, `slink_sat_counter`: a saturating counter with clear and increment, instantiated twice under the macro.
- The buffer and FSM stay inline.

## Test plan
- Single word: write 0x12345 to the FIFO with `m_ready = 1`. Expect `m_valid` for 1 cycle with `m_data = 0x12345`, one `fifo_rinc` pulse, then `cnt` returns to 0.
- Burst: 8 words 0..7 with `m_ready = 1`. Expect 8 consecutive `m_valid` cycles in order, `stat_words = 8`, `stat_stalls = 0`.
- Backpressure: 6 words queued, `m_ready = 0` for 5 cycles. Expect exactly 2 pops, `fifo_rinc` low afterwards, `m_data` stable, `stat_stalls = 5`. Release `m_ready` and expect all 6 words in order with none lost.
- Flush: 2 words buffered, 4 in the FIFO, `flush` pulsed for 1 cycle. Expect `m_valid = 0` from the next cycle, 4 discard pops, `flush_done` for 1 cycle, and `flush_busy` high from the cycle after `flush` is sampled until the `flush_done` cycle. Then write 0xA and expect it to be the next output.
- Reset mid-stream: `reset_n = 0` for 1 cycle with `cnt = 2`. Expect `m_valid = 0`, `m_data = 0`, `fifo_rinc = 0` during reset, and stats 0.
- Stats saturation: with `STAT_WIDTH = 4`, 20 transfers give `stat_words = 15`. Then `stat_clr` gives 0 on the next cycle.

Source files
------------

// File: rtl/slink_fifo_pkg.sv
// Shared S-Link FIFO definitions: read-adapter state encoding and buffer sizing.
package slink_fifo_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } rd_state_t;

   localparam int unsigned RD_BUF_DEPTH = 2;
   localparam int unsigned RD_CNT_W     = $clog2(RD_BUF_DEPTH + 1);

endpackage

// File: rtl/slink_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module slink_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/slink_fifo_rd_stream.sv
// Read-side adapter: FWFT FIFO port to registered valid/ready stream with flush.
// Optional statistics counters are built when SLINK_FIFO_RD_STATS_EN is defined.
module slink_fifo_rd_stream
   import slink_fifo_pkg::*;
#(
   parameter int unsigned DATA_SIZE  = 40,
   parameter int unsigned STAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fifo_rempty,
   input  logic [DATA_SIZE-1:0]  fifo_rdata,
   output logic                  fifo_rinc,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_SIZE-1:0]  m_data,
   input  logic                  flush,
   output logic                  flush_busy,
   output logic                  flush_done
`ifdef SLINK_FIFO_RD_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [STAT_WIDTH-1:0] stat_words,
   output logic [STAT_WIDTH-1:0] stat_stalls
`endif
);

   if ((DATA_SIZE == 0) || (STAT_WIDTH == 0)) begin : g_param_check
      $error("slink_fifo_rd_stream: DATA_SIZE and STAT_WIDTH must be nonzero");
   end

   rd_state_t             state, state_n;
   logic [RD_CNT_W-1:0]   cnt, cnt_n;
   logic [DATA_SIZE-1:0]  head, head_n;
   logic [DATA_SIZE-1:0]  tail, tail_n;
   logic                  m_valid_n;
   logic                  flush_done_n;
   logic                  pop;
   logic                  retire;

   assign retire    = m_valid & m_ready;
   assign fifo_rinc = pop;
   assign m_data    = head;

   // Pop decision depends only on registered state, never on m_ready.
   always_comb begin
      pop = 1'b0;
      if (reset_n && !fifo_rempty) begin
         if (state == ST_FLUSH) begin
            pop = 1'b1;
         end else begin
            pop = (cnt < RD_CNT_W'(RD_BUF_DEPTH));
         end
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      head_n       = head;
      tail_n       = tail;
      flush_done_n = 1'b0;
      case (state)
         ST_RUN: begin
            if (flush) begin
               // Entering flush drops everything, including a word popped now.
               state_n = ST_FLUSH;
               cnt_n   = '0;
            end else begin
               case (cnt)
                  RD_CNT_W'(0): begin
                     if (pop) head_n = fifo_rdata;
                  end
                  RD_CNT_W'(1): begin
                     if (pop && retire) begin
                        head_n = fifo_rdata;
                     end else if (pop) begin
                        tail_n = fifo_rdata;
                     end
                  end
                  default: begin
                     if (retire) head_n = tail;
                  end
               endcase
               cnt_n = cnt + RD_CNT_W'(pop) - RD_CNT_W'(retire);
            end
         end
         ST_FLUSH: begin
            if (!flush && fifo_rempty) begin
               state_n      = ST_RUN;
               flush_done_n = 1'b1;
            end
         end
         default: begin
            state_n = ST_RUN;
            cnt_n   = '0;
         end
      endcase
      m_valid_n = (state_n == ST_RUN) && (cnt_n != '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_RUN;
         cnt        <= '0;
         head       <= '0;
         tail       <= '0;
         m_valid    <= 1'b0;
         flush_busy <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         head       <= head_n;
         tail       <= tail_n;
         m_valid    <= m_valid_n;
         flush_busy <= (state_n == ST_FLUSH);
         flush_done <= flush_done_n;
      end
   end

`ifdef SLINK_FIFO_RD_STATS_EN
   slink_sat_counter #(
      .WIDTH (STAT_WIDTH)
   ) u_stat_words (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stat_clr),
      .inc     (m_valid & m_ready),
      .count   (stat_words)
   );

   slink_sat_counter #(
      .WIDTH (STAT_WIDTH)
   ) u_stat_stalls (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stat_clr),
      .inc     (m_valid & ~m_ready),
      .count   (stat_stalls)
   );
`endif

endmodule

// File: tb/tb_slink_fifo_rd_stream.sv
// Directed bench for slink_fifo_rd_stream with a queue model of the upstream FWFT FIFO.
module tb_slink_fifo_rd_stream;

   localparam int unsigned DW = 40;
   localparam int unsigned SW = 4;

   logic          clk;
   logic          reset_n;
   logic          fifo_rempty;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_rinc;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          flush;
   logic          flush_busy;
   logic          flush_done;
`ifdef SLINK_FIFO_RD_STATS_EN
   logic          stat_clr;
   logic [SW-1:0] stat_words;
   logic [SW-1:0] stat_stalls;
`endif

   slink_fifo_rd_stream #(
      .DATA_SIZE  (DW),
      .STAT_WIDTH (SW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fifo_rempty (fifo_rempty),
      .fifo_rdata  (fifo_rdata),
      .fifo_rinc   (fifo_rinc),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .flush       (flush),
      .flush_busy  (flush_busy),
      .flush_done  (flush_done)
`ifdef SLINK_FIFO_RD_STATS_EN
      ,
      .stat_clr    (stat_clr),
      .stat_words  (stat_words),
      .stat_stalls (stat_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   int            pops   = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] got[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      q.push_back(w);
      fifo_rempty = 1'b0;
      fifo_rdata  = q[0];
   endtask

   task automatic settle();
      #1;
   endtask

   // One clock: sample handshakes before the edge, then advance the FIFO model.
   task automatic step();
      logic          rinc_s;
      logic          xfer_s;
      logic [DW-1:0] d_s;
      #1;
      rinc_s = fifo_rinc;
      xfer_s = m_valid & m_ready;
      d_s    = m_data;
      @(posedge clk);
      #1;
      if (rinc_s && (q.size() != 0)) begin
         void'(q.pop_front());
         pops++;
      end
      if (xfer_s) got.push_back(d_s);
      fifo_rempty = (q.size() == 0);
      if (q.size() != 0) fifo_rdata = q[0];
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

`ifdef SLINK_FIFO_RD_STATS_EN
   task automatic clear_stats();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
   endtask
`endif

   initial begin
      reset_n     = 1'b0;
      fifo_rempty = 1'b1;
      fifo_rdata  = '0;
      m_ready     = 1'b0;
      flush       = 1'b0;
`ifdef SLINK_FIFO_RD_STATS_EN
      stat_clr    = 1'b0;
`endif

      // Reset state
      steps(2);
      chk("rst_m_valid",    64'(m_valid),    64'(0));
      chk("rst_m_data",     64'(m_data),     64'(0));
      chk("rst_flush_busy", 64'(flush_busy), 64'(0));
      chk("rst_flush_done", 64'(flush_done), 64'(0));
      reset_n = 1'b1;
      step();

      // Single word, one-cycle latency
      m_ready = 1'b1;
      pops = 0;
      got.delete();
      push_word(40'h12345);
      settle();
      chk("single_rinc", 64'(fifo_rinc), 64'(1));
      step();
      chk("single_valid", 64'(m_valid), 64'(1));
      chk("single_data",  64'(m_data),  64'h12345);
      step();
      chk("single_valid_off", 64'(m_valid), 64'(0));
      chk("single_data_hold", 64'(m_data),  64'h12345);
      steps(2);
      chk("single_pops",  64'(pops),       64'(1));
      chk("single_count", 64'(got.size()), 64'(1));

      // Burst of 8 at full rate
`ifdef SLINK_FIFO_RD_STATS_EN
      clear_stats();
`endif
      got.delete();
      for (int i = 0; i < 8; i++) push_word(DW'(i));
      steps(9);
      chk("burst_rate_count", 64'(got.size()), 64'(8));
      for (int i = 0; i < 8; i++) chk("burst_order", 64'(got[i]), 64'(i));
`ifdef SLINK_FIFO_RD_STATS_EN
      chk("burst_stat_words",  64'(stat_words),  64'(8));
      chk("burst_stat_stalls", 64'(stat_stalls), 64'(0));
`endif
      steps(2);

      // Backpressure: only two words buffered while stalled
`ifdef SLINK_FIFO_RD_STATS_EN
      clear_stats();
`endif
      m_ready = 1'b0;
      pops = 0;
      got.delete();
      for (int i = 0; i < 6; i++) push_word(DW'(64'h100 + 64'(i)));
      step();
      chk("bp_first_valid", 64'(m_valid), 64'(1));
      steps(5);
      settle();
      chk("bp_pops",      64'(pops),      64'(2));
      chk("bp_rinc_low",  64'(fifo_rinc), 64'(0));
      chk("bp_valid",     64'(m_valid),   64'(1));
      chk("bp_data_hold", 64'(m_data),    64'h100);
      chk("bp_fifo_left", 64'(q.size()),  64'(4));
`ifdef SLINK_FIFO_RD_STATS_EN
      chk("bp_stat_stalls", 64'(stat_stalls), 64'(5));
`endif
      m_ready = 1'b1;
      steps(10);
      chk("bp_count", 64'(got.size()), 64'(6));
      for (int i = 0; i < 6; i++) chk("bp_order", 64'(got[i]), 64'h100 + 64'(i));
`ifdef SLINK_FIFO_RD_STATS_EN
      chk("bp_stat_words", 64'(stat_words), 64'(6));
`endif

      // Flush with 2 buffered and 4 queued
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(DW'(64'h200 + 64'(i)));
      steps(2);
      chk("fl_pre_valid", 64'(m_valid), 64'(1));
      pops = 0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid_off", 64'(m_valid),    64'(0));
      chk("fl_busy_on",   64'(flush_busy), 64'(1));
      chk("fl_done_early", 64'(flush_done), 64'(0));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("fl_busy_hold", 64'(flush_busy), 64'(1));
         chk("fl_done_hold", 64'(flush_done), 64'(0));
         chk("fl_valid_hold", 64'(m_valid),   64'(0));
      end
      chk("fl_pops", 64'(pops), 64'(4));
      step();
      chk("fl_done_pulse", 64'(flush_done), 64'(1));
      chk("fl_busy_off",   64'(flush_busy), 64'(0));
      step();
      chk("fl_done_single", 64'(flush_done), 64'(0));
      m_ready = 1'b1;
      got.delete();
      push_word(40'hA);
      steps(3);
      chk("fl_next_count", 64'(got.size()), 64'(1));
      chk("fl_next_word",  64'(got[0]),     64'hA);

      // Reset mid-stream with a full buffer
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_word(DW'(64'h300 + 64'(i)));
      steps(2);
      pops = 0;
      reset_n = 1'b0;
      step();
      settle();
      chk("mrst_valid", 64'(m_valid),   64'(0));
      chk("mrst_data",  64'(m_data),    64'(0));
      chk("mrst_rinc",  64'(fifo_rinc), 64'(0));
      chk("mrst_pops",  64'(pops),      64'(0));
`ifdef SLINK_FIFO_RD_STATS_EN
      chk("mrst_stat_words",  64'(stat_words),  64'(0));
      chk("mrst_stat_stalls", 64'(stat_stalls), 64'(0));
`endif
      reset_n = 1'b1;
      m_ready = 1'b1;
      got.delete();
      steps(4);
      chk("mrst_after_count", 64'(got.size()), 64'(1));
      chk("mrst_after_word",  64'(got[0]),     64'h302);

`ifdef SLINK_FIFO_RD_STATS_EN
      // Saturation of a 4-bit counter, then clear
      clear_stats();
      got.delete();
      for (int i = 0; i < 20; i++) push_word(DW'(64'h400 + 64'(i)));
      steps(25);
      chk("sat_count",  64'(got.size()),  64'(20));
      chk("sat_words",  64'(stat_words),  64'(15));
      chk("sat_stalls", 64'(stat_stalls), 64'(0));
      clear_stats();
      chk("sat_clr", 64'(stat_words), 64'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
